// File: rtl/lbist_scan_ctrl.sv
// lbist_scan_ctrl: logic BIST sequencer with LFSR stimulus and MISR signature.
// Optional mismatch counter against ref_po: define LBIST_MISMATCH_CNT_EN.
module lbist_scan_ctrl #(
  parameter int unsigned PI_W      = 36,
  parameter int unsigned PO_W      = 39,
  parameter int unsigned CHAINS    = 1,
  parameter int unsigned CHAIN_LEN = 228,
  parameter int unsigned PATTERNS  = 1024,
  parameter logic [63:0] SEED      = 64'h0000_0000_ACE1_0001,
  parameter logic [63:0] GOLDEN    = 64'h0
) (
  input  logic              CK,
  input  logic              RSTN,
  input  logic              start,
  input  logic              abort,
  output logic [PI_W-1:0]   pi,
  input  logic [PO_W-1:0]   po,
  output logic              scan_en,
  output logic [CHAINS-1:0] scan_in,
  input  logic [CHAINS-1:0] scan_out,
  output logic              busy,
  output logic              done,
  output logic              pass,
  output logic [63:0]       signature,
  input  logic [PO_W-1:0]   ref_po,
  output logic [31:0]       err_cnt
);

  localparam logic [2:0] IDLE    = 3'd0;
  localparam logic [2:0] SHIFT   = 3'd1;
  localparam logic [2:0] CAPTURE = 3'd2;
  localparam logic [2:0] COMPARE = 3'd3;
  localparam logic [2:0] DONE    = 3'd4;

  localparam int unsigned SCW = $clog2(CHAIN_LEN);
  localparam int unsigned PCW = $clog2(PATTERNS + 1);

  localparam logic [SCW-1:0] LAST_SH = SCW'(CHAIN_LEN - 1);
  localparam logic [PCW-1:0] NPAT    = PCW'(PATTERNS);

  // x^64+x^63+x^61+x^60+1, Fibonacci form, shifting left
  function automatic logic [63:0] step(input logic [63:0] v);
    return {v[62:0], v[63] ^ v[62] ^ v[60] ^ v[59]};
  endfunction

  logic [2:0]     state_q, state_d;
  logic [63:0]    lfsr_q, lfsr_d;
  logic [63:0]    misr_q, misr_d;
  logic [SCW-1:0] sh_q, sh_d;
  logic [PCW-1:0] pat_q, pat_d;
  logic           pass_q, pass_d;
  logic           done_q, done_d;

  logic run_req;
  assign run_req = start && (state_q == IDLE || state_q == DONE);

  // Next-state logic for the sequencer, LFSR, MISR and counters
  always_comb begin
    state_d = state_q;
    lfsr_d  = lfsr_q;
    misr_d  = misr_q;
    sh_d    = sh_q;
    pat_d   = pat_q;
    pass_d  = pass_q;
    if (abort) begin
      state_d = IDLE;
      pass_d  = 1'b0;
    end else begin
      unique case (state_q)
        IDLE, DONE: begin
          if (start) begin
            state_d = SHIFT;
            lfsr_d  = SEED;
            misr_d  = '0;
            sh_d    = '0;
            pat_d   = '0;
            pass_d  = 1'b0;
          end
        end
        SHIFT: begin
          lfsr_d = step(lfsr_q);
          if (pat_q != '0) begin
            misr_d = step(misr_q) ^ 64'(scan_out);
          end
          if (sh_q == LAST_SH) begin
            sh_d    = '0;
            state_d = (pat_q < NPAT) ? CAPTURE : COMPARE;
          end else begin
            sh_d = sh_q + SCW'(1);
          end
        end
        CAPTURE: begin
          lfsr_d  = step(lfsr_q);
          misr_d  = step(misr_q) ^ 64'(po);
          pat_d   = pat_q + PCW'(1);
          sh_d    = '0;
          state_d = SHIFT;
        end
        COMPARE: begin
          pass_d  = (misr_q == GOLDEN);
          state_d = DONE;
        end
        default: state_d = IDLE;
      endcase
    end
  end

  // done goes high one cycle after settling in DONE, drops on leaving it
  always_comb begin
    done_d = (state_q == DONE) && (state_d == DONE);
  end

  // Sequencer state registers
  always_ff @(posedge CK or negedge RSTN) begin
    if (!RSTN) begin
      state_q <= IDLE;
      lfsr_q  <= SEED;
      misr_q  <= '0;
      sh_q    <= '0;
      pat_q   <= '0;
      pass_q  <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      lfsr_q  <= lfsr_d;
      misr_q  <= misr_d;
      sh_q    <= sh_d;
      pat_q   <= pat_d;
      pass_q  <= pass_d;
      done_q  <= done_d;
    end
  end

`ifdef LBIST_MISMATCH_CNT_EN
  logic [31:0] err_q, err_d;

  // Count captures where the DUT disagrees with the reference model
  always_comb begin
    err_d = err_q;
    if (abort) begin
      err_d = err_q;
    end else if (run_req) begin
      err_d = '0;
    end else if (state_q == CAPTURE && (po ^ ref_po) != '0
                 && err_q != 32'hFFFF_FFFF) begin
      err_d = err_q + 32'd1;
    end
  end

  // Mismatch counter register
  always_ff @(posedge CK or negedge RSTN) begin
    if (!RSTN) err_q <= '0;
    else       err_q <= err_d;
  end

  assign err_cnt = err_q;
`else
  logic unused_ref;
  logic unused_req;
  assign unused_ref = ^ref_po;
  assign unused_req = run_req;
  assign err_cnt    = '0;
`endif

  // Drive DUT stimulus straight from the LFSR
  always_comb begin
    pi = lfsr_q[PI_W-1:0];
    for (int c = 0; c < int'(CHAINS); c++) begin
      scan_in[c] = lfsr_q[63-c];
    end
  end

  assign scan_en   = (state_q == SHIFT);
  assign busy      = (state_q == SHIFT) || (state_q == CAPTURE)
                  || (state_q == COMPARE);
  assign done      = done_q;
  assign pass      = pass_q;
  assign signature = misr_q;

endmodule

// File: tb/tb_lbist_scan_ctrl.sv
// tb_lbist_scan_ctrl: directed bench for lbist_scan_ctrl.
// CHAIN_LEN=4, PATTERNS=2, CHAINS=1, GOLDEN=0.
module tb_lbist_scan_ctrl;

  logic        CK;
  logic        RSTN;
  logic        start;
  logic        abort;
  logic [35:0] pi;
  logic [38:0] po;
  logic        scan_en;
  logic [0:0]  scan_in;
  logic [0:0]  scan_out;
  logic        busy;
  logic        done;
  logic        pass;
  logic [63:0] signature;
  logic [38:0] ref_po;
  logic [31:0] err_cnt;

  int total = 0;
  int bad   = 0;

  lbist_scan_ctrl #(
    .PI_W(36), .PO_W(39), .CHAINS(1),
    .CHAIN_LEN(4), .PATTERNS(2),
    .SEED(64'h0000_0000_ACE1_0001),
    .GOLDEN(64'h0)
  ) dut (
    .CK(CK), .RSTN(RSTN), .start(start), .abort(abort),
    .pi(pi), .po(po), .scan_en(scan_en), .scan_in(scan_in),
    .scan_out(scan_out), .busy(busy), .done(done), .pass(pass),
    .signature(signature), .ref_po(ref_po), .err_cnt(err_cnt)
  );

  initial CK = 1'b0;
  always #5 CK = ~CK;

  task automatic tick();
    @(posedge CK);
    #1;
  endtask

  task automatic chk(input string tag, input logic [63:0] obs,
                     input logic [63:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  logic [15:0] se_exp;
  logic [31:0] err_exp;

  initial begin
    se_exp = 16'b0011_1101_1110_1111;
`ifdef LBIST_MISMATCH_CNT_EN
    err_exp = 32'd2;
`else
    err_exp = 32'd0;
`endif
    RSTN = 1'b0; start = 1'b0; abort = 1'b0;
    po = '0; ref_po = '0; scan_out = '0;
    #12;
    chk("rst_busy", 64'(busy), 64'd0);
    chk("rst_done", 64'(done), 64'd0);
    chk("rst_pass", 64'(pass), 64'd0);
    chk("rst_se", 64'(scan_en), 64'd0);
    chk("rst_sig", signature, 64'd0);
    chk("rst_err", 64'(err_cnt), 64'd0);
    chk("rst_pi", 64'(pi), 64'h0ACE10001);
    @(negedge CK);
    RSTN = 1'b1;

    // Run 1: all-zero response, timing and stray start while busy
    start = 1'b1;
    tick();
    start = 1'b0;
    chk("r1_pi0", 64'(pi), 64'h0ACE10001);
    chk("r1_busy", 64'(busy), 64'd1);
    for (int k = 0; k < 16; k++) begin
      if (k > 0) tick();
      if (k == 1) chk("r1_pi1", 64'(pi), 64'h159C20002);
      if (k == 2) start = 1'b1;
      if (k == 3) start = 1'b0;
      chk($sformatf("r1_se_e%0d", k), 64'(scan_en), 64'(se_exp[k]));
    end
    chk("r1_done_e15", 64'(done), 64'd0);
    tick();
    chk("r1_done_e16", 64'(done), 64'd1);
    chk("r1_busy_end", 64'(busy), 64'd0);
    chk("r1_pass", 64'(pass), 64'd1);
    chk("r1_sig", signature, 64'd0);
    chk("r1_pi_end", 64'(pi), 64'h840004000);
    chk("r1_sin", 64'(scan_in), 64'd0);

    // Run 2: scan_out[0] stuck at 1, restarted from DONE
    scan_out = 1'b1;
    start = 1'b1;
    tick();
    start = 1'b0;
    chk("r2_done_clr", 64'(done), 64'd0);
    chk("r2_busy", 64'(busy), 64'd1);
    for (int k = 1; k <= 16; k++) tick();
    chk("r2_done", 64'(done), 64'd1);
    chk("r2_sig", signature, 64'h1EF);
    chk("r2_pass", 64'(pass), 64'd0);
    tick();
    chk("r2_sig_hold", signature, 64'h1EF);

    // Run 3: po=1, ref_po=0 so every capture mismatches
    scan_out = 1'b0;
    po = 39'h1;
    ref_po = 39'h0;
    start = 1'b1;
    tick();
    start = 1'b0;
    for (int k = 1; k <= 16; k++) tick();
    chk("r3_done", 64'(done), 64'd1);
    chk("r3_sig", signature, 64'h210);
    chk("r3_pass", 64'(pass), 64'd0);
    chk("r3_err", 64'(err_cnt), 64'(err_exp));

    // Run 4: abort sampled on edge 8
    start = 1'b1;
    tick();
    start = 1'b0;
    for (int k = 1; k <= 7; k++) tick();
    abort = 1'b1;
    start = 1'b1;
    tick();
    abort = 1'b0;
    start = 1'b0;
    chk("ab_busy", 64'(busy), 64'd0);
    chk("ab_done", 64'(done), 64'd0);
    chk("ab_se", 64'(scan_en), 64'd0);
    chk("ab_sig", signature, 64'd4);
    tick();
    chk("ab_idle", 64'(busy), 64'd0);
    start = 1'b1;
    tick();
    start = 1'b0;
    chk("ab_re_pi", 64'(pi), 64'h0ACE10001);
    chk("ab_re_busy", 64'(busy), 64'd1);
    chk("ab_re_sig", signature, 64'd0);

    // Reset mid-shift acts without a clock edge
    tick();
    #2;
    RSTN = 1'b0;
    #1;
    chk("rs_se", 64'(scan_en), 64'd0);
    chk("rs_busy", 64'(busy), 64'd0);
    chk("rs_pi", 64'(pi), 64'h0ACE10001);
    @(negedge CK);
    RSTN = 1'b1;
    tick();
    chk("rs_idle", 64'(busy), 64'd0);
    chk("rs_err", 64'(err_cnt), 64'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/lbist_scan_ctrl.md
LBIST_SCAN_CTRL -- requirements
Module: lbist_scan_ctrl

Interface
REQ-001 Parameter PI_W, 36, primary-input width driven to DUT; legal 1..63.
REQ-002 Parameter PO_W, 39, primary-output width observed from DUT; PO_W+CHAINS SHALL be <= 64.
REQ-003 Parameter CHAINS, 1, number of scan chains; legal 1..8.
REQ-004 Parameter CHAIN_LEN, 228, flops per chain; legal >= 2.
REQ-005 Parameter PATTERNS, 1024, capture patterns per run; legal >= 1.
REQ-006 Parameters SEED (64'h0000_0000_ACE1_0001, must be nonzero) and GOLDEN (64'h0), LFSR seed and expected signature.
REQ-007 CK  input  1  sole clock; all state on rising edge.
REQ-008 RSTN  input  1  asynchronous active-low reset.
REQ-009 start  input  1  run request, sampled in IDLE or DONE.
REQ-010 abort  input  1  return to IDLE from any state.
REQ-011 pi  output  PI_W  DUT primary inputs.
REQ-012 po  input  PO_W  DUT primary outputs.
REQ-013 scan_en  output  1  DUT scan enable.
REQ-014 scan_in  output  CHAINS  per-chain serial data to DUT.
REQ-015 scan_out  input  CHAINS  per-chain serial data from DUT.
REQ-016 busy / done / pass  output  1 each  run status.
REQ-017 signature  output  64  current MISR value.
REQ-018 ref_po  input  PO_W  golden-model outputs (mismatch counter only).
REQ-019 err_cnt  output  32  saturating mismatch count.

Function
REQ-020 LFSR SHALL be 64-bit Fibonacci, polynomial x^64+x^63+x^61+x^60+1, shifting left, advancing once per SHIFT and CAPTURE cycle.
REQ-021 pi SHALL equal lfsr[PI_W-1:0]; scan_in[c] SHALL equal lfsr[63-c].
REQ-022 MISR SHALL be 64-bit, same polynomial, next = step(misr) XOR zero-extended input vector.
REQ-023 States: IDLE, SHIFT, CAPTURE, COMPARE, DONE.
REQ-024 IDLE: scan_en=0, busy=0; start=1 -> SHIFT with lfsr=SEED, misr=0, shift_cnt=0, pat_cnt=0, err_cnt=0, pass=0.
REQ-025 SHIFT: scan_en=1, busy=1; MISR absorbs {scan_out} only when pat_cnt>0; after CHAIN_LEN cycles -> CAPTURE if pat_cnt<PATTERNS, else COMPARE.
REQ-026 CAPTURE: exactly one cycle, scan_en=0; MISR absorbs {po}; pat_cnt increments; -> SHIFT with shift_cnt=0.
REQ-027 COMPARE: one cycle; pass latched as (misr==GOLDEN) -> DONE.
REQ-028 DONE: done=1, busy=0, pass and signature held; start=1 restarts as from IDLE, clearing done.
REQ-029 done SHALL rise on rising edge PATTERNS*(CHAIN_LEN+1)+CHAIN_LEN+2 after the edge sampling start.
REQ-030 abort SHALL win over start and any transition; -> IDLE next edge, done/pass cleared, signature retained.
REQ-031 start while busy SHALL be ignored.

Reset
REQ-032 RSTN low SHALL immediately force: state IDLE, lfsr=SEED, misr=0, counters 0, scan_en=0, busy=0, done=0, pass=0, err_cnt=0.
REQ-033 Reset assertion mid-run SHALL discard the run; release resumes in IDLE.

Configuration
REQ-034 Macro LBIST_MISMATCH_CNT_EN: when defined, each CAPTURE cycle with (po XOR ref_po)!=0 SHALL increment err_cnt, saturating at 32'hFFFF_FFFF; when undefined, err_cnt SHALL be constant 0 and ref_po unused.

Verification
REQ-035 CHAIN_LEN=4, PATTERNS=2, start pulse -> scan_en high 4 cycles, low 1, high 4, low 1, high 4; done rises on edge 16.
REQ-036 po=ref_po=0, scan_out=0, GOLDEN=0 -> signature 0, pass=1.
REQ-037 Same run with scan_out[0] stuck 1 -> signature != 0, pass=0.
REQ-038 abort asserted on edge 7 of a run -> IDLE on edge 8, busy=0, done=0; later start restarts with lfsr=SEED.
REQ-039 RSTN low mid-SHIFT -> scan_en=0 and busy=0 without a clock edge.
REQ-040 With LBIST_MISMATCH_CNT_EN, ref_po=po^1 every capture, PATTERNS=2 -> err_cnt=2 at done; without macro err_cnt=0.
